impulse_sweep_controller: RTL
=============================

IMPULSE_SWEEP_CONTROLLER -- requirements
Module: impulse_sweep_controller

Interface
REQ-001 SHALL have parameter IMPULSE_LENGTH, default 48000, number of impulse words (sweep length N, 2..65535).
REQ-002 SHALL have parameter READ_LATENCY, default 2, impulse RAM read latency L in cycles (1..4), address presented to data valid.
REQ-003 SHALL have port audio_clk  in  1  sole clock; one clock, all logic on rising edge.
REQ-004 SHALL have port rst_in  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port sample_tick  in  1  one-cycle pulse, start one full read sweep.
REQ-006 SHALL have ports load_valid in 1, load_addr in 16, load_data in 1024 signed, and load_ready out 1, forming the impulse-load handshake.
REQ-007 SHALL have ports mem_write_addr out 16, mem_write_data out 1024 signed, mem_write_enable out 1, mem_read_addr out 16, mem_read_data in 1024 signed, all RAM-side.
REQ-008 SHALL have ports tap_data out 1024 signed, tap_index out 16, tap_valid out 1, tap_last out 1, forming the sweep stream to the convolution engine.
REQ-009 SHALL have ports sweep_busy out 1, overrun out 1 (one-cycle pulse) and load_error out 1 (one-cycle pulse), for status.

Function
REQ-010 SHALL implement states IDLE, SWEEP, DRAIN: IDLE to SWEEP on sample_tick; SWEEP to DRAIN after address N-1 issued; DRAIN to IDLE after the tap_last cycle.
REQ-011 SHALL, for a tick in cycle T, present mem_read_addr = k in cycle T+1+k, k = 0..N-1, one address per cycle, no gaps.
REQ-012 SHALL register tap outputs: tap_data = RAM word k, tap_index = k, tap_valid = 1 in cycle T+2+k+L.
REQ-013 SHALL assert tap_last with tap_index N-1 only (cycle T+1+N+L); IDLE from T+2+N+L.
REQ-014 SHALL drive sweep_busy high from T+1 through the tap_last cycle inclusive, i.e. for N+L+1 cycles.
REQ-015 SHALL hold mem_read_addr at 0 outside SWEEP.
REQ-016 SHALL, on sample_tick while not IDLE, drop the tick, leave the current sweep undisturbed, and pulse overrun for one cycle.
REQ-017 SHALL drive load_ready = (state == IDLE) and not sample_tick, so a tick wins over a simultaneous load.
REQ-018 SHALL register an accepted load (load_valid and load_ready) with load_addr < N, giving mem_write_enable = 1 with that addr and data exactly one cycle later.
REQ-019 SHALL, for an accepted load with load_addr >= N, issue no write and pulse load_error one cycle later.
REQ-020 SHALL keep mem_write_enable low in all other cycles; the write port is never used during SWEEP or DRAIN.
REQ-021 SHALL compare addresses in 16 bits unsigned and leave data unmodified (pass-through, no arithmetic).

Reset
REQ-022 SHALL, on rst_in in any state (including mid-sweep), enter IDLE at the next edge and clear the in-flight valid pipeline.
REQ-023 SHALL reset all registered outputs to zero: tap_valid, tap_last, tap_index, tap_data, mem_write_enable, mem_write_addr, mem_write_data, mem_read_addr, sweep_busy, overrun and load_error.
REQ-024 SHALL produce no tap_valid after reset until a new sample_tick, even if RAM data is still in flight.

Structure
REQ-025 SHALL place WORD_W = 1024, ADDR_W = 16 and the state enum in shared package impulse_pkg.
REQ-026 SHALL use one sub-module, latency_shift_reg, a parameterised L-stage shift register that delays valid, last and index alongside RAM latency and is synchronously clearable.

Verification (bench uses behavioural RAM model, IMPULSE_LENGTH = 8, READ_LATENCY = 2)
REQ-027 SHALL cover: load words 0..7 with value addr*3, then tick at T -> taps 0..7 in T+4..T+11, tap_last at T+11, busy T+1..T+11.
REQ-028 SHALL cover: tick at T+5 during sweep -> overrun pulse at T+6; stream unchanged; no second sweep.
REQ-029 SHALL cover: load_valid and sample_tick same cycle in IDLE -> load_ready = 0, sweep starts; load accepted first IDLE cycle after sweep.
REQ-030 SHALL cover: load_addr = 8 accepted -> no mem_write_enable; load_error pulse next cycle.
REQ-031 SHALL cover: rst_in at T+6 mid-sweep -> IDLE and all outputs 0 at T+7; no tap_valid until next tick.
REQ-032 SHALL cover: back-to-back ticks at T and T+12 -> second sweep proceeds with no overrun, taps at T+16..T+23.

Source files
------------

// File: rtl/impulse_pkg.sv
// rtl/impulse_pkg.sv - shared widths and sweep state encoding
//
// Purpose: word and address widths plus the sweep FSM state type, shared by
// the sweep controller and its delay line.
// Ports: none (package).
package impulse_pkg;

  localparam int WORD_W = 1024;
  localparam int ADDR_W = 16;

  // Tag carried through the RAM-latency delay line: {valid, last, index}.
  localparam int TAG_W = ADDR_W + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2
  } sweep_state_e;

endpackage

// File: rtl/latency_shift_reg.sv
// rtl/latency_shift_reg.sv - clearable fixed-depth delay line
//
// Purpose: delays a bundle of control bits by DEPTH cycles so it lines up
// with data coming back from a pipelined RAM read.
// Ports:
//   clk_i   - clock, rising edge
//   clr_i   - synchronous clear of every stage
//   data_i  - word entering the delay line
//   data_o  - word that entered DEPTH cycles earlier
module latency_shift_reg #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 18
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/impulse_sweep_controller.sv
// rtl/impulse_sweep_controller.sv - impulse RAM loader and read-sweep sequencer
//
// Purpose: loads impulse words into an external RAM while idle and, on each
// sample tick, reads the whole impulse out in address order as a tap stream.
// Ports:
//   audio_clk, rst_in          - clock and synchronous active-high reset
//   sample_tick                - starts one full read sweep
//   load_valid/addr/data/ready - impulse word load handshake
//   mem_write_*                - RAM write port (used only from IDLE loads)
//   mem_read_addr/data         - RAM read port, READ_LATENCY cycles
//   tap_data/index/valid/last  - sweep stream to the convolution engine
//   sweep_busy, overrun, load_error - status
module impulse_sweep_controller
  import impulse_pkg::*;
#(
  parameter int IMPULSE_LENGTH = 48000,
  parameter int READ_LATENCY   = 2
) (
  input  logic                     audio_clk,
  input  logic                     rst_in,
  input  logic                     sample_tick,
  input  logic                     load_valid,
  input  logic [ADDR_W-1:0]        load_addr,
  input  logic signed [WORD_W-1:0] load_data,
  output logic                     load_ready,
  output logic [ADDR_W-1:0]        mem_write_addr,
  output logic signed [WORD_W-1:0] mem_write_data,
  output logic                     mem_write_enable,
  output logic [ADDR_W-1:0]        mem_read_addr,
  input  logic signed [WORD_W-1:0] mem_read_data,
  output logic signed [WORD_W-1:0] tap_data,
  output logic [ADDR_W-1:0]        tap_index,
  output logic                     tap_valid,
  output logic                     tap_last,
  output logic                     sweep_busy,
  output logic                     overrun,
  output logic                     load_error
);

  localparam logic [ADDR_W-1:0] LEN       = ADDR_W'(IMPULSE_LENGTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = LEN - 1'b1;

  sweep_state_e state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic busy_q, busy_d;

  logic overrun_q, overrun_d;
  logic wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q;
  logic signed [WORD_W-1:0] wr_data_q;
  logic load_error_q, load_error_d;
  logic load_accept;
  logic addr_in_range;

  logic tap_valid_q, tap_last_q;
  logic [ADDR_W-1:0] tap_index_q;
  logic signed [WORD_W-1:0] tap_data_q;

  logic issue_valid, issue_last;
  logic [TAG_W-1:0] issue_tag, dly_tag;
  logic dly_valid, dly_last;
  logic [ADDR_W-1:0] dly_index;

  // ---------------------------------------------------------------------------
  // Sweep FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_addr_d = '0;
    busy_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_tick) begin
          state_d = SWEEP;
        end
      end
      SWEEP: begin
        if (rd_addr_q == LAST_ADDR) begin
          state_d = DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      DRAIN: begin
        // The last tap is on the outputs this cycle; nothing is left in flight.
        if (tap_last_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // A tick arriving while a sweep is still running is dropped and flagged.
  assign overrun_d = sample_tick && (state_q != IDLE);

  // ---------------------------------------------------------------------------
  // Load path: only open in IDLE, and a tick in the same cycle takes priority
  // ---------------------------------------------------------------------------
  assign load_ready    = (state_q == IDLE) && !sample_tick;
  assign load_accept   = load_valid && load_ready;
  assign addr_in_range = (load_addr < LEN);
  assign wr_en_d       = load_accept && addr_in_range;
  assign load_error_d  = load_accept && !addr_in_range;

  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      load_error_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      wr_en_q      <= wr_en_d;
      load_error_q <= load_error_d;
      overrun_q    <= overrun_d;
      if (wr_en_d) begin
        wr_addr_q <= load_addr;
        wr_data_q <= load_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: the tag issued with each address is delayed by the RAM latency
  // so valid/last/index meet the returned word, then everything is registered.
  // ---------------------------------------------------------------------------
  assign issue_valid = (state_q == SWEEP);
  assign issue_last  = issue_valid && (rd_addr_q == LAST_ADDR);
  assign issue_tag   = {issue_valid, issue_last, rd_addr_q};

  latency_shift_reg #(
    .DEPTH (READ_LATENCY),
    .WIDTH (TAG_W)
  ) u_tag_delay (
    .clk_i  (audio_clk),
    .clr_i  (rst_in),
    .data_i (issue_tag),
    .data_o (dly_tag)
  );

  assign {dly_valid, dly_last, dly_index} = dly_tag;

  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      tap_valid_q <= 1'b0;
      tap_last_q  <= 1'b0;
      tap_index_q <= '0;
      tap_data_q  <= '0;
    end else begin
      tap_valid_q <= dly_valid;
      tap_last_q  <= dly_last;
      if (dly_valid) begin
        tap_index_q <= dly_index;
        tap_data_q  <= mem_read_data;
      end
    end
  end

  assign mem_read_addr    = rd_addr_q;
  assign mem_write_addr   = wr_addr_q;
  assign mem_write_data   = wr_data_q;
  assign mem_write_enable = wr_en_q;
  assign tap_data         = tap_data_q;
  assign tap_index        = tap_index_q;
  assign tap_valid        = tap_valid_q;
  assign tap_last         = tap_last_q;
  assign sweep_busy       = busy_q;
  assign overrun          = overrun_q;
  assign load_error       = load_error_q;

endmodule
